// File: rtl/operand_capture_pkg.sv
// ---------------------------------------------------------------------------
// operand_capture_pkg
// Shared definitions for the operand capture FIFO:
//   OP_WIDTH / OP_DEPTH : default operand width and FIFO depth
//   operand_pair_t      : one captured {a, b} operand pair
//   state_e             : two-state output control (EMPTY / ACTIVE)
//   ptr_bits()          : pointer width for a given depth (one extra wrap bit)
// ---------------------------------------------------------------------------
package operand_capture_pkg;

   localparam int OP_WIDTH = 4;
   localparam int OP_DEPTH = 4;

   typedef struct packed {
      logic [OP_WIDTH-1:0] a;
      logic [OP_WIDTH-1:0] b;
   } operand_pair_t;

   typedef enum logic {
      EMPTY  = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   // The extra MSB distinguishes full from empty when the low bits match.
   function automatic int ptr_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/operand_capture_if.sv
// ---------------------------------------------------------------------------
// operand_capture_if
// Bundles the operand capture bus.
//   Ain/Bin/Ein : strobed operand pair from the enable stage
//   Aout/Bout   : head-of-FIFO pair (zero when Vout=0)
//   Vout/Rdy    : downstream valid/ready handshake
//   Full/Count  : occupancy status
//   Ovf         : sticky overflow flag
// Modports: master = producer/consumer environment, slave = operand_capture.
// ---------------------------------------------------------------------------
interface operand_capture_if
   import operand_capture_pkg::*;
#(
   parameter int WIDTH = OP_WIDTH,
   parameter int DEPTH = OP_DEPTH
);

   logic [WIDTH-1:0]       Ain;
   logic [WIDTH-1:0]       Bin;
   logic                   Ein;
   logic [WIDTH-1:0]       Aout;
   logic [WIDTH-1:0]       Bout;
   logic                   Vout;
   logic                   Rdy;
   logic                   Full;
   logic [$clog2(DEPTH):0] Count;
   logic                   Ovf;

   modport master (
      output Ain, Bin, Ein, Rdy,
      input  Aout, Bout, Vout, Full, Count, Ovf
   );

   modport slave (
      input  Ain, Bin, Ein, Rdy,
      output Aout, Bout, Vout, Full, Count, Ovf
   );

endinterface

// File: rtl/operand_capture_fifo_mem.sv
// ---------------------------------------------------------------------------
// operand_fifo_mem
// DEPTH x (2*WIDTH) register array with one synchronous write port and one
// asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data {a, b}
//   raddr : read address
//   rdata : read data, combinational from raddr
// ---------------------------------------------------------------------------
module operand_fifo_mem
   import operand_capture_pkg::*;
#(
   parameter int WIDTH = OP_WIDTH,
   parameter int DEPTH = OP_DEPTH
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [2*WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [2*WIDTH-1:0]         rdata
);

   logic [2*WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage has no reset; the pointers alone decide which entries are
   // live, so resetting the array would only cost flops and reset routing.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/operand_capture.sv
// ---------------------------------------------------------------------------
// operand_capture
// Captures strobed A/B operand pairs into a small first-word-fall-through
// FIFO and presents them to the downstream datapath over valid/ready.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (discards buffered pairs)
//   bus   : operand_capture_if.slave (Ain/Bin/Ein in, Aout/Bout/Vout out,
//           Rdy in, Full/Count/Ovf status out)
// Build option: OPERAND_CAPTURE_ZERO_DROP_EN -- when defined, a strobed
// all-zero pair is treated as the enable stage's gated-off value and is
// neither pushed nor counted as an overflow.
// ---------------------------------------------------------------------------
module operand_capture
   import operand_capture_pkg::*;
#(
   parameter int WIDTH = OP_WIDTH,
   parameter int DEPTH = OP_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   operand_capture_if.slave  bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = ptr_bits(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pair_t;

   state_e           state_q,  state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             ovf_q,    ovf_d;

   logic             vout;
   logic             full;
   logic [PTR_W-1:0] count;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             drop;
   pair_t            wr_pair;
   pair_t            rd_pair;

   // ------------------------------------------------------------------
   // Status derived from registered state only
   // ------------------------------------------------------------------
   assign vout  = (state_q == ACTIVE);
   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[AW-1:0]  == rd_ptr_q[AW-1:0]);
   // Modulo-2*DEPTH subtraction gives occupancy directly.
   assign count = wr_ptr_q - rd_ptr_q;

`ifdef OPERAND_CAPTURE_ZERO_DROP_EN
   assign push_req = bus.Ein && ((bus.Ain != '0) || (bus.Bin != '0));
`else
   assign push_req = bus.Ein;
`endif

   // A pop in the same cycle frees the head slot, so a full FIFO can still
   // accept the incoming pair.
   assign pop  = vout && bus.Rdy;
   assign push = push_req && (!full || pop);
   assign drop = push_req && full && !pop;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // NOTE: every variable gets its hold value before any branch so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (drop) ovf_d    = 1'b1;

      unique case (state_q)
         EMPTY:  if (push) state_d = ACTIVE;
         ACTIVE: if (pop && !push && (count == PTR_ONE)) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // NOTE: non-blocking assignments make every flop sample the pre-edge
   // values, independent of statement order inside the block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   assign wr_pair = '{a: bus.Ain, b: bus.Bin};

   operand_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && rst_n),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (wr_pair),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rd_pair)
   );

   // ------------------------------------------------------------------
   // Outputs: head pair is forced to zero while nothing is valid
   // ------------------------------------------------------------------
   assign bus.Aout  = vout ? rd_pair.a : '0;
   assign bus.Bout  = vout ? rd_pair.b : '0;
   assign bus.Vout  = vout;
   assign bus.Full  = full;
   assign bus.Count = count;
   assign bus.Ovf   = ovf_q;

endmodule

// File: tb/tb_operand_capture.sv
// ---------------------------------------------------------------------------
// tb_operand_capture
// Self-checking bench for operand_capture (WIDTH=4, DEPTH=4): a table of
// directed vectors followed by a randomized run compared against a
// queue-based reference model. Honours OPERAND_CAPTURE_ZERO_DROP_EN.
// ---------------------------------------------------------------------------
module tb_operand_capture;
   import operand_capture_pkg::*;

   localparam int W = 4;
   localparam int D = 4;

   logic clk;
   logic rst_n;

   operand_capture_if #(.WIDTH(W), .DEPTH(D)) bus ();

   operand_capture #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------
   // Directed vector table
   // -------------------------------------------------------------------
   typedef struct {
      logic       rst_n;
      logic       ein;
      logic [3:0] a;
      logic [3:0] b;
      logic       rdy;
      logic       vout;
      logic [3:0] ea;
      logic [3:0] eb;
      logic [2:0] cnt;
      logic       full;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic [3:0] a, input logic [3:0] b,
                      input logic rd, input logic v, input logic [3:0] ea, input logic [3:0] eb,
                      input int c, input logic f, input logic o);
      vec_t t;
      t.rst_n = r;  t.ein = e;   t.a = a;     t.b = b;    t.rdy = rd;
      t.vout  = v;  t.ea  = ea;  t.eb = eb;   t.cnt = 3'(c);
      t.full  = f;  t.ovf = o;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, input logic e, input logic [3:0] a,
                        input logic [3:0] b, input logic rd);
      rst_n   = r;
      bus.Ein = e;
      bus.Ain = a;
      bus.Bin = b;
      bus.Rdy = rd;
   endtask

   // -------------------------------------------------------------------
   // Reference model: a plain queue of pairs plus a sticky flag
   // -------------------------------------------------------------------
   operand_pair_t model_q[$];
   bit            model_ovf;

   task automatic model_step(input logic r, input logic e, input logic [3:0] a,
                             input logic [3:0] b, input logic rd);
      bit            accept;
      bit            will_pop;
      operand_pair_t p;
      if (!r) begin
         model_q.delete();
         model_ovf = 1'b0;
         return;
      end
      accept = e;
`ifdef OPERAND_CAPTURE_ZERO_DROP_EN
      if (a == 4'd0 && b == 4'd0) accept = 1'b0;
`endif
      will_pop = (model_q.size() > 0) && rd;
      if (accept && model_q.size() == D && !will_pop) model_ovf = 1'b1;
      else if (accept) begin
         if (will_pop) void'(model_q.pop_front());
         will_pop = 1'b0;
         p.a = a;
         p.b = b;
         model_q.push_back(p);
      end
      if (will_pop) void'(model_q.pop_front());
   endtask

   task automatic check_model(input string tag);
      logic [3:0] ea, eb;
      ea = (model_q.size() > 0) ? model_q[0].a : 4'd0;
      eb = (model_q.size() > 0) ? model_q[0].b : 4'd0;
      check({tag, ".vout"},  32'(bus.Vout),  32'(model_q.size() > 0));
      check({tag, ".aout"},  32'(bus.Aout),  32'(ea));
      check({tag, ".bout"},  32'(bus.Bout),  32'(eb));
      check({tag, ".count"}, 32'(bus.Count), 32'(model_q.size()));
      check({tag, ".full"},  32'(bus.Full),  32'(model_q.size() == D));
      check({tag, ".ovf"},   32'(bus.Ovf),   32'(model_ovf));
   endtask

   initial begin
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

      //    rst ein  a     b    rdy | vout ea   eb  cnt full ovf
      add(0, 0, 4'h0, 4'h0, 0,   0, 4'h0, 4'h0, 0, 0, 0);  // reset state
      add(1, 1, 4'h9, 4'h5, 0,   1, 4'h9, 4'h5, 1, 0, 0);  // first-pair latency
      add(1, 0, 4'h0, 4'h0, 1,   0, 4'h0, 4'h0, 0, 0, 0);  // drain to empty
      add(1, 1, 4'h9, 4'h5, 1,   1, 4'h9, 4'h5, 1, 0, 0);  // Rdy ignored when empty
      add(1, 1, 4'hC, 4'hC, 1,   1, 4'hC, 4'hC, 1, 0, 0);  // push+pop at one entry
      add(1, 1, 4'h4, 4'h9, 1,   1, 4'h4, 4'h9, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 1,   0, 4'h0, 4'h0, 0, 0, 0);  // outputs forced to zero
      add(1, 1, 4'h1, 4'h2, 0,   1, 4'h1, 4'h2, 1, 0, 0);  // fill with Rdy=0
      add(1, 1, 4'h3, 4'h4, 0,   1, 4'h1, 4'h2, 2, 0, 0);
      add(1, 1, 4'h5, 4'h6, 0,   1, 4'h1, 4'h2, 3, 0, 0);
      add(1, 1, 4'h7, 4'h8, 0,   1, 4'h1, 4'h2, 4, 1, 0);  // full after 4th
      add(1, 1, 4'h9, 4'hA, 0,   1, 4'h1, 4'h2, 4, 1, 1);  // 5th dropped, Ovf
      add(1, 0, 4'h0, 4'h0, 1,   1, 4'h3, 4'h4, 3, 0, 1);  // drain first four
      add(1, 0, 4'h0, 4'h0, 1,   1, 4'h5, 4'h6, 2, 0, 1);
      add(1, 0, 4'h0, 4'h0, 1,   1, 4'h7, 4'h8, 1, 0, 1);
      add(1, 0, 4'h0, 4'h0, 1,   0, 4'h0, 4'h0, 0, 0, 1);  // Ovf is sticky
      add(0, 0, 4'h0, 4'h0, 0,   0, 4'h0, 4'h0, 0, 0, 0);  // reset clears Ovf
      add(1, 1, 4'h1, 4'h1, 0,   1, 4'h1, 4'h1, 1, 0, 0);
      add(1, 1, 4'h2, 4'h2, 0,   1, 4'h1, 4'h1, 2, 0, 0);
      add(1, 1, 4'h3, 4'h3, 0,   1, 4'h1, 4'h1, 3, 0, 0);
      add(1, 1, 4'h4, 4'h4, 0,   1, 4'h1, 4'h1, 4, 1, 0);
      add(1, 1, 4'h5, 4'h5, 1,   1, 4'h2, 4'h2, 4, 1, 0);  // full push+pop, no Ovf
      add(1, 0, 4'h0, 4'h0, 0,   1, 4'h2, 4'h2, 4, 1, 0);
      add(1, 0, 4'h0, 4'h0, 1,   1, 4'h3, 4'h3, 3, 0, 0);  // 3 buffered
      add(0, 1, 4'hF, 4'hF, 1,   0, 4'h0, 4'h0, 0, 0, 0);  // mid-run reset, Ein ignored
      add(1, 1, 4'h6, 4'hA, 0,   1, 4'h6, 4'hA, 1, 0, 0);  // new pair alone at head
      add(1, 0, 4'h0, 4'h0, 1,   0, 4'h0, 4'h0, 0, 0, 0);
`ifdef OPERAND_CAPTURE_ZERO_DROP_EN
      add(1, 1, 4'h0, 4'h0, 0,   0, 4'h0, 4'h0, 0, 0, 0);  // zero pair not pushed
`else
      add(1, 1, 4'h0, 4'h0, 0,   1, 4'h0, 4'h0, 1, 0, 0);  // zero pair pushed
`endif
      add(1, 0, 4'h0, 4'h0, 1,   0, 4'h0, 4'h0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].ein, vecs[i].a, vecs[i].b, vecs[i].rdy);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d.vout", i),  32'(bus.Vout),  32'(vecs[i].vout));
         check($sformatf("vec%0d.aout", i),  32'(bus.Aout),  32'(vecs[i].ea));
         check($sformatf("vec%0d.bout", i),  32'(bus.Bout),  32'(vecs[i].eb));
         check($sformatf("vec%0d.count", i), 32'(bus.Count), 32'(vecs[i].cnt));
         check($sformatf("vec%0d.full", i),  32'(bus.Full),  32'(vecs[i].full));
         check($sformatf("vec%0d.ovf", i),   32'(bus.Ovf),   32'(vecs[i].ovf));
      end

      // ----------------------------------------------------------------
      // Randomized run against the queue model
      // ----------------------------------------------------------------
      begin
         logic       r, e, rd;
         logic [3:0] a, b;
         int         rdy_pct;
         r = 1'b0; e = 1'b0; rd = 1'b0; a = 4'h0; b = 4'h0;
         drive(r, e, a, b, rd);
         @(posedge clk);
         model_step(r, e, a, b, rd);
         #1;
         check_model("rnd_reset");
         rdy_pct = 50;
         for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) rdy_pct = $urandom_range(5, 95);
            r  = ($urandom_range(0, 249) != 0);
            e  = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < rdy_pct);
            a  = 4'($urandom);
            b  = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
               a = 4'h0;
               b = 4'h0;
            end
            drive(r, e, a, b, rd);
            @(posedge clk);
            model_step(r, e, a, b, rd);
            #1;
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_capture.md
# operand_capture

Receiving end of the operand enable path: samples 4-bit A/B operand pairs strobed by an enable line, buffers them in a small FIFO, and presents them one pair at a time to the downstream datapath over a valid/ready handshake. It sits between the enable/gating stage and the ALU. It absorbs bursts when the consumer stalls and flags any pair lost to overflow.

## Interface
- WIDTH, 4, bit width of each operand A and B
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- Ain  input  WIDTH  operand A from enable stage
- Bin  input  WIDTH  operand B from enable stage
- Ein  input  1  enable/strobe: pair on Ain/Bin is valid this cycle
- Aout  output  WIDTH  head-of-FIFO operand A
- Bout  output  WIDTH  head-of-FIFO operand B
- Vout  output  1  head pair valid
- Rdy  input  1  downstream accepts head pair this cycle
- Full  output  1  FIFO holds DEPTH entries
- Count  output  $clog2(DEPTH)+1  current occupancy
- Ovf  output  1  sticky: a strobed pair was dropped

## Operation
- Push: at posedge, when Ein=1 and (Full=0 or pop this cycle), {Ain,Bin} is written at the write pointer and the pointer advances.
- Pop: at posedge, when Vout=1 and Rdy=1, the read pointer advances.
- Simultaneous push and pop: both occur; Count is unchanged; allowed when full (the freed slot takes the new pair) and when holding 1 entry. No push-to-head bypass when empty.
- Overflow: Ein=1, Full=1, no pop → pair dropped, contents unchanged, Ovf set to 1. Ovf is cleared only by reset.
- Pop with Vout=0 is ignored; Rdy is don't-care when empty.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
- Aout/Bout show storage at the read pointer (first-word fall-through). When Vout=0 they are driven to 0, never stale data.
- Two-state control: EMPTY (Vout=0) and ACTIVE (Vout=1). EMPTY→ACTIVE on push; ACTIVE→EMPTY on pop with Count=1 and no push.

## Timing
- Reset (rst_n=0 at posedge): Aout=0, Bout=0, Vout=0, Full=0, Count=0, Ovf=0, pointers=0. Storage contents are not reset.
- rst_n asserted mid-operation discards all buffered pairs the same edge. Ein during a reset cycle is ignored.
- Latency: pair strobed at edge N → Vout=1 with that pair on Aout/Bout after edge N (visible in cycle N+1).
- Back-to-back: with Rdy held 1, one pair per cycle is sustained at full throughput.
- Full, Count and Vout are registered-state derived and update on the same edge as the pointers.
- Ovf rises on the edge following the dropped strobe.

## Configuration
- OPERAND_CAPTURE_ZERO_DROP_EN defined: a strobed pair with Ain=0 and Bin=0 is not pushed (the gated-off value of the enable stage), and it never sets Ovf.
- Undefined: all-zero pairs are pushed like any other pair.

## Structure
- Package operand_capture_pkg: WIDTH/DEPTH defaults, operand pair struct typedef {a,b}, state enum {EMPTY, ACTIVE}.
- Sub-module operand_fifo_mem: DEPTH×(2·WIDTH) register array, one write port, one asynchronous read port. Pointer, count, flag and state logic stay in operand_capture.

## Test plan
- Reset, then Ein=1 Ain=1001 Bin=0101 for one cycle with Rdy=0 → next cycle Vout=1, Aout=1001, Bout=0101, Count=1.
- Strobe 1001/0101, 1100/1100, 0100/1001 with Rdy=1 → same order out one per cycle, Count returns to 0, Vout=0, Aout=Bout=0.
- Rdy=0, push 5 distinct pairs at DEPTH=4 → Full=1 after 4th, 5th dropped, Ovf=1. Then Rdy=1 → exactly the first 4 pairs drain.
- Full FIFO, Ein=1 and Rdy=1 same cycle → head popped, new pair accepted, Count stays 4, Ovf stays 0.
- Ein=1 Ain=0000 Bin=0000 → with ZERO_DROP_EN Count stays 0. Without it Count=1 and 0000/0000 is output.
- 3 pairs buffered, rst_n=0 one cycle → Vout=0, Count=0, Full=0, Ovf=0. A subsequent push appears alone at the head.
